pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
Game-flow controller for pong_main. Derives a once-per-frame tick from the VGA V/H counters and runs a fixed update sequence (paddles, ball, collision check, result) in vertical blanking. Owns the serve/play/point/game-over state machine, the scores and the status LEDs. Ball and paddle datapaths only move when this block strobes them.

Parameters:
SCR_H, 11'd20, active lines; frame tick fires at V_CNT==SCR_H, H_CNT==0.
POINT_FRAMES, 8'd60, frames held in POINT before the next serve.
WIN_SCORE, 4'd9, score that ends the game.
BLINK_LOG2, 4, LED[3] toggles every 2**BLINK_LOG2 frames in OVER.

Ports:
CLK  in  1  system clock (75 MHz).
RST  in  1  synchronous, active-low reset.
H_CNT  in  11  pixel-in-line counter from vga_sync_gen.
V_CNT  in  11  line-in-frame counter from vga_sync_gen.
Button_A  in  1  player A button, asynchronous.
Button_B  in  1  player B button, asynchronous.
MISS_A  in  1  ball passed A's (left) edge; valid in the RES cycle.
MISS_B  in  1  ball passed B's (right) edge; valid in the RES cycle.
PAD_STB  out  1  one-cycle paddle-update strobe.
BALL_STB  out  1  one-cycle ball-move strobe (PLAY only).
CHK_STB  out  1  one-cycle collision/edge-check strobe (PLAY only).
BALL_RST  out  1  hold ball at screen centre.
BALL_DIR  out  1  serve direction: 0 = toward A (left), 1 = toward B.
SCORE_A  out  4  player A score.
SCORE_B  out  4  player B score.
LED  out  4  [0] A serves, [1] B serves, [2] PLAY, [3] OVER blink.

Behaviour:
- Reset (RST==0 at a CLK edge): game=WAIT, seq=IDLE, SERVER=A, scores 0, frame/blink counters 0, all strobes 0, BALL_RST=1, BALL_DIR=1, LED=4'b0001. Reset mid-sequence or mid-point aborts immediately with no partial score update. All outputs are registered.
- Buttons: each goes through pong_btn_edge (2-FF sync plus rising-edge detect). A press reaches the FSM as a 1-cycle pulse 3 cycles after the pin rises. Holding a button gives one pulse only.
- Frame tick: registered, 1 cycle, when V_CNT==SCR_H && H_CNT==0.
- Sequencer: IDLE, then on tick PAD, BALL, CHK, RES, then IDLE. One state per cycle.
  - PAD_STB is high in PAD in every game state.
  - BALL_STB is high in BALL, and CHK_STB in CHK, only when game==PLAY.
  - MISS_A/MISS_B are sampled only in RES.
  - A tick that arrives while seq!=IDLE is ignored.
- Game FSM (changes only in the RES cycle, except the button-driven transitions):
  - WAIT: BALL_RST=1. A button pulse from SERVER goes to PLAY on the next edge, with BALL_DIR=~SERVER (A serves rightward, BALL_DIR=1). The non-server's button is ignored. Both pressed in the same cycle counts as the server's press.
  - PLAY: BALL_RST=0. In RES:
    - MISS_A only: SCORE_B+1, SERVER=A, go to POINT.
    - MISS_B only: SCORE_A+1, SERVER=B, go to POINT.
    - Both: no score change, SERVER unchanged, go to POINT.
    - Neither: stay in PLAY.
  - POINT: BALL_RST=1. The frame counter is cleared on entry and increments on each RES. At count==POINT_FRAMES-1, go to OVER if either score==WIN_SCORE, else to WAIT.
  - OVER: BALL_RST=1. LED[3] toggles each 2**BLINK_LOG2 frames. Any button pulse clears both scores, sets SERVER=A and goes to WAIT.
- Scores saturate at WIN_SCORE and never wrap.
- LED[1:0] one-hot shows SERVER in WAIT and POINT, and is 00 otherwise. LED[2] = (game==PLAY).

Decomposition:
- pong_pkg:
  - game-state encoding: WAIT, PLAY, POINT, OVER.
  - sequencer encoding: IDLE, PAD, BALL, CHK, RES.
  - side constants: SIDE_A=0, SIDE_B=1.
  - score width: 4.
- Sub-module pong_btn_edge (synchroniser plus rising-edge pulse), instantiated twice.

Test Plan:
- Reset release with SCR_H=20 -> BALL_RST=1, LED=0001, scores 0. At V_CNT=20, H_CNT=0, PAD_STB pulses; BALL_STB and CHK_STB stay 0.
- Button_B then Button_A pressed in WAIT -> B ignored. A gives game=PLAY 4 cycles after the pin rises (3-cycle sync/edge path plus 1 FSM register), BALL_DIR=1, LED=0100. The next tick gives PAD, BALL and CHK strobes on consecutive cycles.
- PLAY, MISS_B=1 in RES -> SCORE_A=1, SERVER=B, POINT. With POINT_FRAMES=2, WAIT after 2 frames with LED=0010.
- MISS_A and MISS_B both high in RES -> scores unchanged, POINT entered. MISS_A asserted outside RES is ignored.
- WIN_SCORE=3, A scores 3 times -> OVER after the POINT hold, SCORE_A=3 with no further increment, LED[3] blinks. A button press gives scores 0 and WAIT with SERVER=A.
- RST low during the BALL sequencer cycle -> no CHK_STB, all reset values at the next edge.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pong_pkg                                                  |
// | Purpose  : Shared encodings for the pong game-flow controller: game  |
// |            states, update-sequencer states, side constants, score    |
// |            width and a saturating score increment helper.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package pong_pkg;

  localparam int unsigned SCORE_W = 4;

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  typedef enum logic [1:0] {
    GAME_WAIT  = 2'd0,
    GAME_PLAY  = 2'd1,
    GAME_POINT = 2'd2,
    GAME_OVER  = 2'd3
  } game_e;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_PAD  = 3'd1,
    SEQ_BALL = 3'd2,
    SEQ_CHK  = 3'd3,
    SEQ_RES  = 3'd4
  } seq_e;

  // Score increment that sticks at the limit instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pong_btn_edge                                             |
// | Purpose  : Two-flop synchroniser for an asynchronous push button     |
// |            followed by a registered rising-edge detector. A press    |
// |            yields exactly one 1-cycle pulse, 3 cycles after the pin  |
// |            rises; holding the button gives no further pulses.        |
// | Ports    : clk     - system clock                                    |
// |            rst_n   - synchronous active-low reset                    |
// |            i_btn   - raw asynchronous button pin                     |
// |            o_pulse - one-cycle press pulse                           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pong_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;  // previous synchronised level, for edge detect
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    pulse_d = sync2_q & ~sync3_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pong_game_ctrl                                            |
// | Purpose  : Pong game-flow controller. Derives a frame tick from the  |
// |            VGA counters, runs the PAD/BALL/CHK/RES update sequence   |
// |            during blanking, and owns the WAIT/PLAY/POINT/OVER state  |
// |            machine, scores and status LEDs.                          |
// | Ports    : CLK, RST (sync, active-low)                               |
// |            H_CNT, V_CNT       - VGA position counters                |
// |            Button_A, Button_B - asynchronous player buttons          |
// |            MISS_A, MISS_B     - edge-miss flags, sampled in RES      |
// |            PAD_STB, BALL_STB, CHK_STB - one-cycle datapath strobes   |
// |            BALL_RST, BALL_DIR - ball hold / serve direction          |
// |            SCORE_A, SCORE_B   - scores                               |
// |            LED                - [0] A serves [1] B serves            |
// |                                 [2] PLAY [3] OVER blink              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [10:0]        SCR_H        = 11'd20,
  parameter logic [7:0]         POINT_FRAMES = 8'd60,
  parameter logic [SCORE_W-1:0] WIN_SCORE    = 4'd9,
  parameter int unsigned        BLINK_LOG2   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [10:0]        H_CNT,
  input  logic [10:0]        V_CNT,
  input  logic               Button_A,
  input  logic               Button_B,
  input  logic               MISS_A,
  input  logic               MISS_B,
  output logic               PAD_STB,
  output logic               BALL_STB,
  output logic               CHK_STB,
  output logic               BALL_RST,
  output logic               BALL_DIR,
  output logic [SCORE_W-1:0] SCORE_A,
  output logic [SCORE_W-1:0] SCORE_B,
  output logic [3:0]         LED
);

  logic btn_a, btn_b;

  pong_btn_edge u_btn_a (.clk(CLK), .rst_n(RST), .i_btn(Button_A), .o_pulse(btn_a));
  pong_btn_edge u_btn_b (.clk(CLK), .rst_n(RST), .i_btn(Button_B), .o_pulse(btn_b));

  logic                  tick_q, tick_d;
  seq_e                  seq_q, seq_d;
  game_e                 game_q, game_d;
  logic                  server_q, server_d;
  logic [SCORE_W-1:0]    score_a_q, score_a_d;
  logic [SCORE_W-1:0]    score_b_q, score_b_d;
  logic [7:0]            frame_q, frame_d;
  logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;
  logic                  blink_q, blink_d;
  logic                  pad_stb_q, pad_stb_d;
  logic                  ball_stb_q, ball_stb_d;
  logic                  chk_stb_q, chk_stb_d;
  logic                  ball_rst_q, ball_rst_d;
  logic                  ball_dir_q, ball_dir_d;
  logic [3:0]            led_q, led_d;

  logic is_res;
  logic server_press;

  always_comb begin
    tick_d       = (V_CNT == SCR_H) && (H_CNT == '0);
    is_res       = (seq_q == SEQ_RES);
    server_press = (server_q == SIDE_A) ? btn_a : btn_b;

    // Update sequencer: ticks arriving mid-sequence are dropped.
    seq_d = SEQ_IDLE;
    case (seq_q)
      SEQ_IDLE: seq_d = tick_q ? SEQ_PAD : SEQ_IDLE;
      SEQ_PAD:  seq_d = SEQ_BALL;
      SEQ_BALL: seq_d = SEQ_CHK;
      SEQ_CHK:  seq_d = SEQ_RES;
      default:  seq_d = SEQ_IDLE;
    endcase

    game_d      = game_q;
    server_d    = server_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    frame_d     = frame_q;
    ball_dir_d  = ball_dir_q;
    // Blink phase only runs while OVER, so it always starts dark.
    blink_cnt_d = (game_q == GAME_OVER) ? blink_cnt_q : '0;
    blink_d     = (game_q == GAME_OVER) ? blink_q : 1'b0;

    case (game_q)
      GAME_WAIT: begin
        if (server_press) begin
          game_d     = GAME_PLAY;
          ball_dir_d = ~server_q;
        end
      end
      GAME_PLAY: begin
        if (is_res && (MISS_A || MISS_B)) begin
          game_d  = GAME_POINT;
          frame_d = '0;
          if (MISS_A && !MISS_B) begin
            score_b_d = sat_inc(score_b_q, WIN_SCORE);
            server_d  = SIDE_A;
          end else if (MISS_B && !MISS_A) begin
            score_a_d = sat_inc(score_a_q, WIN_SCORE);
            server_d  = SIDE_B;
          end
        end
      end
      GAME_POINT: begin
        if (is_res) begin
          if (frame_q == POINT_FRAMES - 8'd1) begin
            frame_d = '0;
            game_d  = ((score_a_q == WIN_SCORE) || (score_b_q == WIN_SCORE))
                      ? GAME_OVER : GAME_WAIT;
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
      end
      default: begin  // GAME_OVER
        if (btn_a || btn_b) begin
          game_d    = GAME_WAIT;
          score_a_d = '0;
          score_b_d = '0;
          server_d  = SIDE_A;
        end else if (is_res) begin
          blink_cnt_d = blink_cnt_q + 1'b1;
          if (blink_cnt_q == '1) begin
            blink_d = ~blink_q;
          end
        end
      end
    endcase

    // Outputs are registered from next-state so they line up with state.
    pad_stb_d  = (seq_d == SEQ_PAD);
    ball_stb_d = (seq_d == SEQ_BALL) && (game_d == GAME_PLAY);
    chk_stb_d  = (seq_d == SEQ_CHK)  && (game_d == GAME_PLAY);
    ball_rst_d = (game_d != GAME_PLAY);
    led_d      = 4'b0000;
    if ((game_d == GAME_WAIT) || (game_d == GAME_POINT)) begin
      led_d[1:0] = (server_d == SIDE_A) ? 2'b01 : 2'b10;
    end
    led_d[2] = (game_d == GAME_PLAY);
    led_d[3] = (game_d == GAME_OVER) && blink_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      tick_q      <= 1'b0;
      seq_q       <= SEQ_IDLE;
      game_q      <= GAME_WAIT;
      server_q    <= SIDE_A;
      score_a_q   <= '0;
      score_b_q   <= '0;
      frame_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      pad_stb_q   <= 1'b0;
      ball_stb_q  <= 1'b0;
      chk_stb_q   <= 1'b0;
      ball_rst_q  <= 1'b1;
      ball_dir_q  <= 1'b1;
      led_q       <= 4'b0001;
    end else begin
      tick_q      <= tick_d;
      seq_q       <= seq_d;
      game_q      <= game_d;
      server_q    <= server_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      frame_q     <= frame_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      pad_stb_q   <= pad_stb_d;
      ball_stb_q  <= ball_stb_d;
      chk_stb_q   <= chk_stb_d;
      ball_rst_q  <= ball_rst_d;
      ball_dir_q  <= ball_dir_d;
      led_q       <= led_d;
    end
  end

  assign PAD_STB  = pad_stb_q;
  assign BALL_STB = ball_stb_q;
  assign CHK_STB  = chk_stb_q;
  assign BALL_RST = ball_rst_q;
  assign BALL_DIR = ball_dir_q;
  assign SCORE_A  = score_a_q;
  assign SCORE_B  = score_b_q;
  assign LED      = led_q;

endmodule
`default_nettype wire
